updown_mod_counter: RTL

//  Parametrised successor to the fixed 8-bit free-running up counter.

---
 rtl/updown_mod_counter_if.sv | 38 +++
 rtl/updown_mod_counter.sv | 92 +++++++++
 2 files changed

// File: rtl/updown_mod_counter_if.sv
// ---------------------------------------------------------------------------
// updown_mod_counter_if
//   Control/status bundle for the up/down modulus counter.
//   master : drives the controls (en, up, load, load_val, limit) and observes
//            the counter state (count, at_limit, tc).
//   slave  : the counter itself.
// Signals
//   en        count enable, one step per cycle while high
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous parallel load of load_val
//   load_val  [WIDTH] value taken on load
//   limit     [WIDTH] inclusive upper bound of the counting range
//   count     [WIDTH] registered counter value
//   at_limit  combinational boundary indication for the current direction
//   tc        registered terminal-count pulse
// ---------------------------------------------------------------------------
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             at_limit;
  logic             tc;

  modport master (
    output en, up, load, load_val, limit,
    input  count, at_limit, tc
  );

  modport slave (
    input  en, up, load, load_val, limit,
    output count, at_limit, tc
  );
endinterface

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter
//   Parametrised up/down sequence counter with enable, synchronous load,
//   runtime inclusive limit, wrap or saturate behaviour at the boundaries and
//   a registered terminal-count pulse.
// Parameters
//   WIDTH      counter width in bits (>= 2)
//   SATURATE   0 = wrap at boundaries, 1 = hold at boundaries
//   RESET_VAL  count value after reset
// Ports
//   clk    clock, all state changes on the rising edge
//   reset  synchronous active-high reset (overrides load and en)
//   bus    slave side of updown_mod_counter_if (controls in, count/at_limit/tc out)
// ---------------------------------------------------------------------------
module updown_mod_counter #(
  parameter int WIDTH     = 8,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  updown_mod_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_COUNT = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO        = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_count_s;
  logic             next_tc_s;
  logic             boundary_s;

  // Boundary for the current direction; counts parked above limit count as
  // "at the top" going up, but only zero is the bottom going down.
  always_comb begin
    boundary_s = 1'b0;
    if (bus.up) begin
      boundary_s = (count_r >= bus.limit);
    end else begin
      boundary_s = (count_r == ZERO);
    end
  end

  // Next count / terminal-count selection; load wins over en, idle holds.
  always_comb begin
    next_count_s = count_r;
    next_tc_s    = 1'b0;
    if (bus.load) begin
      // Loaded value is taken verbatim, even above limit.
      next_count_s = bus.load_val;
      next_tc_s    = 1'b0;
    end else if (bus.en) begin
      if (boundary_s) begin
        next_tc_s = 1'b1;
        if (bus.up) begin
          next_count_s = (SATURATE != 0) ? bus.limit : ZERO;
        end else begin
          next_count_s = (SATURATE != 0) ? ZERO : bus.limit;
        end
      end else begin
        next_tc_s = 1'b0;
        // Modulo 2^WIDTH arithmetic; a count above limit walks back down.
        if (bus.up) begin
          next_count_s = count_r + ONE;
        end else begin
          next_count_s = count_r - ONE;
        end
      end
    end else begin
      next_count_s = count_r;
      next_tc_s    = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= RESET_COUNT;
      tc_r    <= 1'b0;
    end else begin
      count_r <= next_count_s;
      tc_r    <= next_tc_s;
    end
  end

  assign bus.count    = count_r;
  assign bus.tc       = tc_r;
  assign bus.at_limit = boundary_s;

endmodule
